// File: rtl/mvm_pkg.sv
// mvm_pkg: shared state encoding, default sizes and counter-width helper for the streaming MVM
package mvm_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, MAC, OUT} state_t;
  localparam int M_DEF = 3;
  localparam int N_DEF = 3;
  localparam int IW_DEF = 8;
  localparam int OW_DEF = 16;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mvm_mac.sv
// mvm_mac: registered signed operands feeding a wrapping multiply-accumulate with sticky overflow
module mvm_mac
  import mvm_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  output logic signed [OW-1:0] acc,
  output logic                 ovf
);
  logic signed [IW-1:0] op_a, op_b;
  logic signed [2*IW-1:0] prod;
  logic signed [OW-1:0] p, sum;
  assign prod = (2*IW)'(op_a) * (2*IW)'(op_b);
  assign p = OW'(prod);
  assign sum = acc + p;
  // operand capture, then accumulate; overflow is sign disagreement between equal-signed addends and their sum
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= '0;
      op_b <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      if (ld) begin
        op_a <= a;
        op_b <= b;
      end
      if (clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (en) begin
        acc <= sum;
        ovf <= ovf | ((acc[OW-1] == p[OW-1]) && (sum[OW-1] != acc[OW-1]));
      end
    end
  end
endmodule

// File: rtl/mvm_stream_param.sv
// mvm_stream_param: streaming y = A*x with optional reuse of the stored matrix between jobs
module mvm_stream_param
  import mvm_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [IW-1:0] s_data,
  input  logic                 s_reuse,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [OW-1:0] m_data,
  output logic                 m_overflow,
  output logic                 busy
);
  localparam int AW = clog2_min1(M*N);
  localparam int XW = clog2_min1(N);
  localparam int CW = clog2_min1(N+2);
  localparam int RW = clog2_min1(M);
  state_t state;
  logic a_loaded;
  logic [AW-1:0] ai;
  logic [XW-1:0] xi, xr;
  logic [CW-1:0] c;
  logic [RW-1:0] r, oi;
  logic signed [IW-1:0] a_mem [M*N];
  logic signed [IW-1:0] x_mem [N];
  logic signed [OW-1:0] y_mem [M];
  logic y_ovf [M];
  logic ld, clear, en, ovf;
  logic signed [OW-1:0] acc;
  assign s_ready = !reset && (state == IDLE || state == LOAD_A || state == LOAD_X);
  assign busy = state != IDLE;
  assign xr = XW'(c);
  assign ld = state == MAC && c < CW'(N);
  assign clear = state == MAC && c == '0;
  assign en = state == MAC && c != '0 && c <= CW'(N);
  mvm_mac #(.IW(IW), .OW(OW)) u_mac (
    .clk(clk), .reset(reset), .ld(ld), .clear(clear), .en(en),
    .a(a_mem[ai]), .b(x_mem[xr]), .acc(acc), .ovf(ovf)
  );
  // job sequencing: operand loading, fixed-length per-row MAC schedule, then ordered result drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_loaded <= 1'b0;
      ai <= '0;
      xi <= '0;
      c <= '0;
      r <= '0;
      oi <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          c <= '0;
          r <= '0;
          if (s_reuse && a_loaded) begin
            x_mem[0] <= s_data;
            xi <= XW'(1);
            ai <= '0;
            state <= (N == 1) ? MAC : LOAD_X;
          end else begin
            a_mem[0] <= s_data;
            ai <= AW'(1);
            state <= LOAD_A;
          end
        end
        LOAD_A: if (s_valid) begin
          a_mem[ai] <= s_data;
          if (ai == AW'(M*N-1)) begin
            a_loaded <= 1'b1;
            ai <= '0;
            xi <= '0;
            state <= LOAD_X;
          end else ai <= ai + AW'(1);
        end
        LOAD_X: if (s_valid) begin
          x_mem[xi] <= s_data;
          if (xi == XW'(N-1)) begin
            ai <= '0;
            c <= '0;
            r <= '0;
            state <= MAC;
          end else xi <= xi + XW'(1);
        end
        MAC: begin
          ai <= ld ? ai + AW'(1) : ai;
          if (c == CW'(N+1)) begin
            y_mem[r] <= acc;
            y_ovf[r] <= ovf;
            c <= '0;
            oi <= '0;
            r <= (r == RW'(M-1)) ? '0 : r + RW'(1);
            state <= (r == RW'(M-1)) ? OUT : MAC;
          end else c <= c + CW'(1);
        end
        OUT: if (!m_valid) begin
          m_valid <= 1'b1;
          m_data <= y_mem[oi];
          m_overflow <= y_ovf[oi];
        end else if (m_ready) begin
          if (oi == RW'(M-1)) begin
            m_valid <= 1'b0;
            m_data <= '0;
            m_overflow <= 1'b0;
            state <= IDLE;
          end else begin
            oi <= oi + RW'(1);
            m_data <= y_mem[oi+RW'(1)];
            m_overflow <= y_ovf[oi+RW'(1)];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mvm_stream_param.sv
// tb_mvm_stream_param: randomized stimulus checked against an integer model of y = A*x
module tb_mvm_stream_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic s_valid = 1'b0, s_reuse = 1'b0, m_ready = 1'b0;
  logic signed [7:0] s_data = '0;
  logic s_ready, m_valid, m_overflow, busy;
  logic signed [15:0] m_data;
  logic v2 = 1'b0, mr2 = 1'b0;
  logic signed [7:0] d2 = '0;
  logic rdy2, mv2, mo2, b2;
  logic signed [15:0] md2;
  int checks = 0, errors = 0;
  int a_m[9], x_m[3];
  int exp_y[$];
  bit exp_o[$];

  mvm_stream_param dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_reuse(s_reuse), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_overflow(m_overflow), .busy(busy)
  );
  mvm_stream_param #(.M(2), .N(4), .IW(8), .OW(16)) dut2 (
    .clk(clk), .reset(reset), .s_valid(v2), .s_ready(rdy2), .s_data(d2),
    .s_reuse(1'b0), .m_valid(mv2), .m_ready(mr2), .m_data(md2),
    .m_overflow(mo2), .busy(b2)
  );

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic void model();
    exp_y.delete();
    exp_o.delete();
    for (int i = 0; i < 3; i++) begin
      int w = 0, t;
      bit o = 0;
      for (int j = 0; j < 3; j++) begin
        t = w + a_m[i*3+j] * x_m[j];
        if (t > 32767 || t < -32768) o = 1;
        w = int'(shortint'(t));
      end
      exp_y.push_back(w);
      exp_o.push_back(o);
    end
  endfunction

  task automatic push(input int d, input bit reu);
    int k;
    @(posedge clk); #1;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin @(posedge clk); #1; end
    s_data = 8'(d);
    s_reuse = reu;
    s_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_ready) break;
      if (t > 200) begin
        checks++; errors++;
        $display("FAIL push_timeout s_ready=%0b required 1", s_ready);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_reuse = 1'($urandom_range(0, 1));
    s_data = 8'($urandom);
  endtask

  task automatic send_job(input int n_a, input bit reu);
    int q[$];
    for (int i = 0; i < n_a; i++) q.push_back(a_m[i]);
    for (int j = 0; j < 3; j++) q.push_back(x_m[j]);
    foreach (q[k]) push(q[k], k == 0 ? reu : 1'($urandom_range(0, 1)));
  endtask

  task automatic collect(input string name, input bit rnd);
    int got = 0;
    @(posedge clk); #1;
    for (int t = 0; got < 3 && t < 500; t++) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'(exp_y[got])) begin
          errors++;
          $display("FAIL %s_y%0d m_data=%0d required %0d", name, got, m_data, exp_y[got]);
        end
        checks++;
        if (m_overflow !== exp_o[got]) begin
          errors++;
          $display("FAIL %s_ovf%0d m_overflow=%0b required %0b", name, got, m_overflow, exp_o[got]);
        end
        got++;
      end else if (!m_valid) begin
        checks++;
        if (m_data !== 16'sd0) begin
          errors++;
          $display("FAIL %s_idle_data m_data=%0d required 0", name, m_data);
        end
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    if (got < 3) begin
      checks++; errors++;
      $display("FAIL %s_timeout transfers=%0d required 3", name, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, busy, m_valid, m_overflow} !== 4'b0 || m_data !== 16'sd0) begin
      errors++;
      $display("FAIL reset_outputs ready/busy/valid/ovf=%b data=%0d required 0000 0", {s_ready, busy, m_valid, m_overflow}, m_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release s_ready=%0b required 1", s_ready);
    end
  endtask

  task automatic test_default();
    int a0[9] = '{1, -8, 3, 9, -5, 11, -7, 8, -9};
    int x0[3] = '{1, -22, 3};
    a_m = a0;
    x_m = x0;
    exp_y = '{186, 152, -210};
    exp_o = '{0, 0, 0};
    send_job(9, 1'b0);
    collect("default", 1'b1);
  endtask

  task automatic test_reuse();
    int x0[3] = '{10, 11, 12};
    x_m = x0;
    exp_y = '{-42, 167, -90};
    exp_o = '{0, 0, 0};
    send_job(0, 1'b1);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reuse_in_mac s_ready=%0b busy=%0b required 0 1", s_ready, busy);
    end
    collect("reuse", 1'b1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) a_m[i] = (i / 3 == 1) ? 127 : rnd8();
    x_m = '{127, 127, 127};
    model();
    checks++;
    if (exp_y[1] != -17149 || exp_o[1] != 1'b1) begin
      errors++;
      $display("FAIL overflow_model y1=%0d o=%0b required -17149 1", exp_y[1], exp_o[1]);
    end
    send_job(9, 1'b0);
    collect("overflow", 1'b1);
  endtask

  task automatic test_backpressure();
    logic signed [15:0] d0;
    logic o0;
    int t;
    for (int i = 0; i < 9; i++) a_m[i] = rnd8();
    for (int j = 0; j < 3; j++) x_m[j] = rnd8();
    model();
    send_job(9, 1'b0);
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    checks++;
    if (!m_valid) begin
      errors++;
      $display("FAIL bp_wait m_valid=%0b required 1", m_valid);
    end
    d0 = m_data;
    o0 = m_overflow;
    checks++;
    if (d0 !== 16'(exp_y[0])) begin
      errors++;
      $display("FAIL bp_first m_data=%0d required %0d", d0, exp_y[0]);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== d0 || m_overflow !== o0) begin
        errors++;
        $display("FAIL bp_hold valid=%0b data=%0d ovf=%0b required 1 %0d %0b", m_valid, m_data, m_overflow, d0, o0);
      end
    end
    collect("bp", 1'b0);
    m_ready = 1'b1;
    t = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_valid) t++;
    end
    m_ready = 1'b0;
    checks++;
    if (t != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra extra_valid=%0d busy=%0b required 0 0", t, busy);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) a_m[i] = rnd8();
    for (int i = 0; i < 10; i++) push(i < 9 ? a_m[i] : rnd8(), 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_load_x busy=%0b s_ready=%0b required 1 1", busy, s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready s_ready=%0b required 0", s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after busy=%0b s_ready=%0b required 0 1", busy, s_ready);
    end
    for (int i = 0; i < 9; i++) a_m[i] = rnd8();
    for (int j = 0; j < 3; j++) x_m[j] = rnd8();
    model();
    send_job(9, 1'b1);
    collect("mid", 1'b1);
  endtask

  task automatic test_params();
    int q[12] = '{1, 2, 3, 4, -1, -2, -3, -4, 1, 1, 1, 1};
    int ey[2] = '{10, -10};
    int lat = 0;
    @(posedge clk); #1;
    foreach (q[k]) begin
      d2 = 8'(q[k]);
      v2 = 1'b1;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (rdy2) break;
      end
      @(posedge clk); #1;
      v2 = 1'b0;
    end
    for (lat = 1; lat < 100; lat++) begin
      @(posedge clk); #1;
      if (mv2) break;
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL param_latency cycles=%0d required 13", lat);
    end
    mr2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (mv2 !== 1'b1 || md2 !== 16'(ey[i]) || mo2 !== 1'b0) begin
        errors++;
        $display("FAIL param_y%0d valid=%0b data=%0d ovf=%0b required 1 %0d 0", i, mv2, md2, mo2, ey[i]);
      end
      @(posedge clk); #1;
    end
    mr2 = 1'b0;
    @(negedge clk);
    checks++;
    if (mv2 !== 1'b0 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL param_done valid=%0b busy=%0b required 0 0", mv2, b2);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_reuse();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
